// File: rtl/pwm_comp_nch_if.sv
// rtl/pwm_comp_nch_if.sv - control inputs and gate-drive outputs of pwm_comp_nch
interface pwm_comp_nch_if #(
   parameter int WIDTH = 10,
   parameter int NCH   = 3,
   parameter int DT_W  = 6
);
   logic                  ce;
   logic [WIDTH-1:0]      period;
   logic [NCH*WIDTH-1:0]  duty;
   logic [DT_W-1:0]       dead;
   logic                  load;
   logic [NCH-1:0]        out_s;
   logic [NCH-1:0]        out_nots;
   logic                  clk_int;

   modport master (
      output ce, period, duty, dead, load,
      input  out_s, out_nots, clk_int
   );

   modport slave (
      input  ce, period, duty, dead, load,
      output out_s, out_nots, clk_int
   );
endinterface

// File: rtl/pwm_comp_nch.sv
// rtl/pwm_comp_nch.sv - multi-channel complementary PWM on a shared carrier; PWM_CENTER_ALIGNED_EN selects an up/down carrier
module pwm_comp_nch #(
   parameter int WIDTH = 10,
   parameter int NCH   = 3,
   parameter int DT_W  = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   pwm_comp_nch_if.slave bus
);

   localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [DT_W-1:0]  DT_ONE = {{(DT_W-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]     cnt;
   logic [WIDTH-1:0]     cnt_next;
   logic                 wrap;

   logic [WIDTH-1:0]     p_act;
   logic [NCH*WIDTH-1:0] d_act;
   logic [DT_W-1:0]      t_act;
   logic [WIDTH-1:0]     p_sh;
   logic [NCH*WIDTH-1:0] d_sh;
   logic [DT_W-1:0]      t_sh;
   logic                 pending;

   logic [NCH-1:0]       ref_now;
   logic [NCH-1:0]       ref_r;
   logic [NCH-1:0]       ref_r_next;
   logic [DT_W-1:0]      dcnt      [NCH];
   logic [DT_W-1:0]      dcnt_next [NCH];
   logic [NCH-1:0]       s_next;
   logic [NCH-1:0]       nots_next;

`ifdef PWM_CENTER_ALIGNED_EN
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
   dir_t dir;
   dir_t dir_next;

   // Carrier direction register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dir <= DIR_UP;
      end else begin
         dir <= dir_next;
      end
   end

   // Up/down carrier: climb to P, fall back, wrap only on the step into 0
   always_comb begin
      cnt_next = cnt;
      dir_next = dir;
      wrap     = 1'b0;
      if (bus.ce) begin
         if (dir == DIR_UP && cnt < p_act) begin
            cnt_next = cnt + ONE;
         end else if (cnt <= ONE) begin
            cnt_next = '0;
            dir_next = DIR_UP;
            wrap     = 1'b1;
         end else begin
            cnt_next = cnt - ONE;
            dir_next = DIR_DOWN;
         end
      end
   end
`else
   // Sawtooth carrier: count 0..P then wrap
   always_comb begin
      cnt_next = cnt;
      wrap     = 1'b0;
      if (bus.ce) begin
         if (cnt == p_act) begin
            cnt_next = '0;
            wrap     = 1'b1;
         end else begin
            cnt_next = cnt + ONE;
         end
      end
   end
`endif

   // Carrier counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_next;
      end
   end

   // Shadow capture on any load; active settings change only at the wrap
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_act   <= '1;
         d_act   <= '0;
         t_act   <= '0;
         p_sh    <= '0;
         d_sh    <= '0;
         t_sh    <= '0;
         pending <= 1'b0;
      end else begin
         if (bus.load) begin
            p_sh <= bus.period;
            d_sh <= bus.duty;
            t_sh <= bus.dead;
         end
         if (wrap && bus.load) begin
            p_act   <= bus.period;
            d_act   <= bus.duty;
            t_act   <= bus.dead;
            pending <= 1'b0;
         end else if (wrap && pending) begin
            p_act   <= p_sh;
            d_act   <= d_sh;
            t_act   <= t_sh;
            pending <= 1'b0;
         end else if (bus.load) begin
            pending <= 1'b1;
         end
      end
   end

   // Per-channel reference, dead-time countdown and gate next-state
   always_comb begin
      ref_r_next = ref_r;
      ref_now    = '0;
      s_next     = '0;
      nots_next  = '0;
      for (int i = 0; i < NCH; i++) begin
         dcnt_next[i] = dcnt[i];
         ref_now[i]   = (cnt < d_act[i*WIDTH +: WIDTH]);
         if (bus.ce) begin
            if (ref_now[i] != ref_r[i]) begin
               ref_r_next[i] = ref_now[i];
               dcnt_next[i]  = t_act;
            end else if (dcnt[i] != '0) begin
               dcnt_next[i] = dcnt[i] - DT_ONE;
            end
         end
         s_next[i]    = ref_r_next[i]  & (dcnt_next[i] == '0);
         nots_next[i] = ~ref_r_next[i] & (dcnt_next[i] == '0);
      end
   end

   // Channel state and registered gate / strobe outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_r        <= '0;
         bus.out_s    <= '0;
         bus.out_nots <= '0;
         bus.clk_int  <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            dcnt[i] <= '0;
         end
      end else begin
         ref_r        <= ref_r_next;
         bus.out_s    <= s_next;
         bus.out_nots <= nots_next;
         bus.clk_int  <= wrap;
         for (int i = 0; i < NCH; i++) begin
            dcnt[i] <= dcnt_next[i];
         end
      end
   end

endmodule

// File: tb/tb_pwm_comp_nch.sv
// tb/tb_pwm_comp_nch.sv - self-checking bench for pwm_comp_nch
module tb_pwm_comp_nch;
   localparam int WIDTH = 10;
   localparam int NCH   = 3;
   localparam int DT_W  = 6;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   pwm_comp_nch_if #(.WIDTH(WIDTH), .NCH(NCH), .DT_W(DT_W)) bus();

   pwm_comp_nch #(.WIDTH(WIDTH), .NCH(NCH), .DT_W(DT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int p, d0, d1, d2, t, div;
      int e_per, e_s0, e_n0, e_g0, e_n1, e_s2;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int mism    = 0;
   int inv_bad = 0;
   int ce_div  = 1;
   int phase   = 0;
   bit rnd_ce  = 0;

   // reference model: carrier position, settings, and per-channel time since last reference change
   int m_pos, m_per, m_dead, m_sh_per, m_sh_dead;
   bit m_pend;
   int m_duty [NCH];
   int m_sh_duty [NCH];
   bit m_level [NCH];
   int m_since [NCH];
   int m_hold [NCH];
   bit [NCH-1:0] e_s, e_n;
   bit e_int;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_cfg(input int p, input int d0, input int d1, input int d2, input int t);
      bus.period = WIDTH'(p);
      bus.duty   = {WIDTH'(d2), WIDTH'(d1), WIDTH'(d0)};
      bus.dead   = DT_W'(t);
   endtask

   task automatic model_reset();
      m_pos = 0; m_per = (1 << WIDTH) - 1; m_dead = 0;
      m_sh_per = 0; m_sh_dead = 0; m_pend = 0;
      for (int i = 0; i < NCH; i++) begin
         m_duty[i] = 0; m_sh_duty[i] = 0;
         m_level[i] = 0; m_since[i] = 1000; m_hold[i] = 0;
      end
      e_s = '0; e_n = '0; e_int = 0;
   endtask

   // advance the model by one clk edge using the inputs presented for that edge
   task automatic model_edge();
      bit wrap, r;
      int in_p, in_t;
      int in_d [NCH];
      in_p = int'(bus.period);
      in_t = int'(bus.dead);
      for (int i = 0; i < NCH; i++) in_d[i] = int'(bus.duty[i*WIDTH +: WIDTH]);
      wrap = bus.ce && (m_pos == m_per);
      if (bus.ce) begin
         for (int i = 0; i < NCH; i++) begin
            r = (m_pos < m_duty[i]);
            if (r != m_level[i]) begin
               m_level[i] = r; m_since[i] = 0; m_hold[i] = m_dead;
            end else if (m_since[i] < 1000) begin
               m_since[i]++;
            end
         end
         m_pos = wrap ? 0 : m_pos + 1;
      end
      if (wrap && bus.load) begin
         m_per = in_p; m_dead = in_t; m_pend = 0;
         for (int i = 0; i < NCH; i++) m_duty[i] = in_d[i];
      end else if (wrap && m_pend) begin
         m_per = m_sh_per; m_dead = m_sh_dead; m_pend = 0;
         for (int i = 0; i < NCH; i++) m_duty[i] = m_sh_duty[i];
      end else if (bus.load) begin
         m_pend = 1;
      end
      if (bus.load) begin
         m_sh_per = in_p; m_sh_dead = in_t;
         for (int i = 0; i < NCH; i++) m_sh_duty[i] = in_d[i];
      end
      e_int = wrap;
      for (int i = 0; i < NCH; i++) begin
         e_s[i] = m_level[i]  && (m_since[i] >= m_hold[i]);
         e_n[i] = !m_level[i] && (m_since[i] >= m_hold[i]);
      end
   endtask

   // one clk: drive ce/load, step the model, sample #1 after the edge
   task automatic step(input bit ld);
      if (rnd_ce) bus.ce = ($urandom_range(0, 3) != 0);
      else        bus.ce = (phase == 0);
      phase = (phase + 1 >= ce_div) ? 0 : phase + 1;
      bus.load = ld;
      model_edge();
      @(posedge clk);
      #1;
      bus.load = 1'b0;
      if ({bus.out_s, bus.out_nots, bus.clk_int} !== {e_s, e_n, e_int}) mism++;
      if ((bus.out_s & bus.out_nots) != '0) inv_bad++;
   endtask

   task automatic wait_int(output bit ok);
      ok = 0;
      for (int k = 0; k < 3000; k++) begin
         step(0);
         if (bus.clk_int) begin ok = 1; break; end
      end
   endtask

   // count cycles from one clk_int to the next
   task automatic measure(input bit at_int, output int per, output int s0, output int n0,
                          output int g0, output int n1, output int s2);
      bit ok;
      ok = at_int;
      per = 0; s0 = 0; n0 = 0; g0 = 0; n1 = 0; s2 = 0;
      if (!at_int) wait_int(ok);
      if (ok) begin
         ok = 0;
         for (int k = 0; k < 3000; k++) begin
            per++;
            s0 += int'(bus.out_s[0]);
            n0 += int'(bus.out_nots[0]);
            g0 += int'(!bus.out_s[0] && !bus.out_nots[0]);
            n1 += int'(bus.out_nots[1]);
            s2 += int'(bus.out_s[2]);
            step(0);
            if (bus.clk_int) begin ok = 1; break; end
         end
      end
      if (!ok) check("measure_timeout", 0, 1);
   endtask

   vec_t tbl [5];

   initial begin
      int per, s0, n0, g0, n1, s2, cnt_s0, cycles;
      bit got, loaded;

      tbl[0] = '{p:99, d0:50, d1:0,  d2:100, t:0, div:1, e_per:100, e_s0:50, e_n0:50, e_g0:0,  e_n1:100, e_s2:100};
      tbl[1] = '{p:99, d0:50, d1:0,  d2:100, t:5, div:1, e_per:100, e_s0:45, e_n0:45, e_g0:10, e_n1:100, e_s2:100};
      tbl[2] = '{p:9,  d0:5,  d1:0,  d2:10,  t:1, div:4, e_per:40,  e_s0:16, e_n0:16, e_g0:8,  e_n1:40,  e_s2:40};
      tbl[3] = '{p:15, d0:3,  d1:7,  d2:16,  t:2, div:1, e_per:16,  e_s0:1,  e_n0:11, e_g0:4,  e_n1:7,   e_s2:16};
      tbl[4] = '{p:20, d0:21, d1:10, d2:0,   t:3, div:2, e_per:42,  e_s0:42, e_n0:0,  e_g0:0,  e_n1:16,  e_s2:0};

      bus.ce = 1'b0; bus.load = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_out_s", int'(bus.out_s), 0);
      check("reset_out_nots", int'(bus.out_nots), 0);
      check("reset_clk_int", int'(bus.clk_int), 0);
      rst_n = 1'b1;

      // table-driven steady-state measurements
      mism = 0; inv_bad = 0;
      foreach (tbl[v]) begin
         ce_div = tbl[v].div; phase = 0;
         set_cfg(tbl[v].p, tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].t);
         step(1);
         measure(0, per, s0, n0, g0, n1, s2);
         measure(0, per, s0, n0, g0, n1, s2);
         check($sformatf("vec%0d_period", v), per, tbl[v].e_per);
         check($sformatf("vec%0d_s0_high", v), s0, tbl[v].e_s0);
         check($sformatf("vec%0d_nots0_high", v), n0, tbl[v].e_n0);
         check($sformatf("vec%0d_gap0", v), g0, tbl[v].e_g0);
         check($sformatf("vec%0d_nots1_high", v), n1, tbl[v].e_n1);
         check($sformatf("vec%0d_s2_high", v), s2, tbl[v].e_s2);
      end
      check("table_model_cycles", mism, 0);
      check("table_overlap", inv_bad, 0);

      // load mid-period: current period keeps its duty, next period takes the new one
      ce_div = 1; phase = 0; mism = 0; inv_bad = 0;
      set_cfg(99, 50, 0, 100, 0);
      step(1);
      measure(0, per, s0, n0, g0, n1, s2);
      cnt_s0 = int'(bus.out_s[0]);
      loaded = 0; got = 0;
      for (int k = 0; k < 300; k++) begin
         if (!loaded && m_pos == 40) begin
            set_cfg(99, 20, 0, 100, 0);
            step(1);
            loaded = 1;
         end else begin
            step(0);
         end
         if (bus.clk_int) begin got = 1; break; end
         cnt_s0 += int'(bus.out_s[0]);
      end
      check("shadow_period_end_seen", int'(got && loaded), 1);
      check("shadow_current_period_s0", cnt_s0, 50);
      measure(1, per, s0, n0, g0, n1, s2);
      check("shadow_next_period_s0", s0, 20);

      // load on the wrap edge applies to the period that starts there
      got = 0;
      for (int k = 0; k < 300; k++) begin
         if (m_pos == 99) begin
            set_cfg(99, 70, 0, 100, 0);
            step(1);
            got = 1;
            break;
         end
         step(0);
      end
      check("wrap_load_strobe", int'(got && bus.clk_int), 1);
      measure(1, per, s0, n0, g0, n1, s2);
      check("wrap_load_s0", s0, 70);
      check("shadow_model_cycles", mism, 0);
      check("shadow_overlap", inv_bad, 0);

      // asynchronous reset while out_s[0] is high
      got = 0;
      for (int k = 0; k < 300; k++) begin
         step(0);
         if (bus.out_s[0]) begin got = 1; break; end
      end
      check("reset_precondition_s0", int'(got), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_out_s", int'(bus.out_s), 0);
      check("async_reset_out_nots", int'(bus.out_nots), 0);
      check("async_reset_clk_int", int'(bus.clk_int), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      model_reset();
      mism = 0; inv_bad = 0; phase = 0;
      cycles = 0;
      for (int k = 1; k <= 3000; k++) begin
         step(0);
         if (bus.clk_int) begin cycles = k; break; end
      end
      check("post_reset_first_wrap", cycles, 1024);
      check("post_reset_model_cycles", mism, 0);

      // randomized settings, loads and ce against the model
      rnd_ce = 1; mism = 0; inv_bad = 0;
      for (int k = 0; k < 5000; k++) begin
         if ($urandom_range(0, 19) == 0) begin
            int p;
            p = $urandom_range(0, 20);
            set_cfg(p, $urandom_range(0, p + 2), $urandom_range(0, p + 2),
                    $urandom_range(0, p + 2), $urandom_range(0, 7));
            step(1);
         end else begin
            step(0);
         end
      end
      check("random_model_cycles", mism, 0);
      check("random_overlap", inv_bad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
